// File: rtl/imm_encode_pipe_pkg.sv
// Shared definitions for the immediate encoder pipeline.
// Holds the format-select encoding (shared with the decode-stage extender),
// the base opcodes the loader and stimulus generator build on, and the S1
// request payload.
package imm_encode_pipe_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned SEL_W = 3;

    // Format select; must stay identical to the decode-stage extender.
    localparam logic [SEL_W-1:0] U_TYPE = 3'b000;
    localparam logic [SEL_W-1:0] J_TYPE = 3'b001;
    localparam logic [SEL_W-1:0] I_TYPE = 3'b010;
    localparam logic [SEL_W-1:0] B_TYPE = 3'b011;
    localparam logic [SEL_W-1:0] S_TYPE = 3'b100;
    localparam logic [SEL_W-1:0] SHAMT  = 3'b101;

    // RV32 major opcodes.
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    // Request captured by stage 1.
    typedef struct packed {
        logic [XLEN-1:0]  base_inst;
        logic [XLEN-1:0]  imm;
        logic [SEL_W-1:0] imm_sel;
    } enc_req_t;

endpackage

// File: rtl/imm_merge.sv
// Combinational immediate merge: scatters imm into the immediate field of
// base_inst for the selected format and flags immediates that do not fit.
// Ports: base_inst, imm, imm_sel in; inst (merged word), err (range/sel error) out.
module imm_merge
    import imm_encode_pipe_pkg::*;
(
    input  logic [XLEN-1:0]  base_inst,
    input  logic [XLEN-1:0]  imm,
    input  logic [SEL_W-1:0] imm_sel,
    output logic [XLEN-1:0]  inst,
    output logic             err
);

    // Error tests are pure equality/zero checks on the full 32-bit imm.
    always_comb begin
        inst = base_inst;
        err  = 1'b0;
        case (imm_sel)
            U_TYPE: begin
                inst[31:12] = imm[31:12];
                err         = (imm[11:0] != 12'd0);
            end
            J_TYPE: begin
                inst[31]    = imm[20];
                inst[30:21] = imm[10:1];
                inst[20]    = imm[11];
                inst[19:12] = imm[19:12];
                err         = imm[0] || (imm[31:20] != {12{imm[20]}});
            end
            I_TYPE: begin
                inst[31:20] = imm[11:0];
                err         = (imm[31:11] != {21{imm[11]}});
            end
            B_TYPE: begin
                inst[31]    = imm[12];
                inst[30:25] = imm[10:5];
                inst[11:8]  = imm[4:1];
                inst[7]     = imm[11];
                err         = imm[0] || (imm[31:12] != {20{imm[12]}});
            end
            S_TYPE: begin
                inst[31:25] = imm[11:5];
                inst[11:7]  = imm[4:0];
                err         = (imm[31:11] != {21{imm[11]}});
            end
            SHAMT: begin
                // funct7 in [31:25] stays from base_inst so srai survives.
                inst[24:20] = imm[4:0];
                err         = (imm[31:5] != 27'd0);
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encode_pipe.sv
// Two-stage pipelined RISC-V immediate encoder with valid/ready on both sides.
// S1 captures the request; S2 registers the merged word and its error flag.
// Ports: CLK, RESETN (async active-low); in_valid/in_ready, imm_sel, imm,
// base_inst (request side); out_valid/out_ready, out_inst, out_err (result
// side); enc_count, err_count saturating transfer statistics.
module imm_encode_pipe
    import imm_encode_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] imm_sel,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  base_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    enc_req_t        s1_req;
    logic            s1_valid;
    logic            s2_load;
    logic            in_xfer;
    logic            out_xfer;
    logic [XLEN-1:0] m_inst;
    logic            m_err;

    // out_valid is the S2 valid bit; S2 advances when empty or draining.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    imm_merge u_merge (
        .base_inst (s1_req.base_inst),
        .imm       (s1_req.imm),
        .imm_sel   (s1_req.imm_sel),
        .inst      (m_inst),
        .err       (m_err)
    );

    // Stage 1: request capture.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_req   <= '{base_inst: base_inst, imm: imm, imm_sel: imm_sel};
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: merged result, held while stalled.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_inst  <= m_inst;
            out_err   <= m_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating statistics on output transfers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (out_xfer) begin
            if (enc_count != '1) begin
                enc_count <= enc_count + CNT_W'(1);
            end
            if (out_err && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imm_encode_pipe.sv
// Directed self-checking bench for imm_encode_pipe.
module tb_imm_encode_pipe;
    import imm_encode_pipe_pkg::*;

    localparam int unsigned CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RESETN;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       imm_sel;
    logic [31:0]      imm;
    logic [31:0]      base_inst;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    int errors = 0;
    int checks = 0;

    imm_encode_pipe #(.CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_sel   (imm_sel),
        .imm       (imm),
        .base_inst (base_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        RESETN   = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;
    endtask

    // One request into an empty pipe with out_ready=1; lat counts rising edges
    // from the accepting edge (inclusive) to the one raising out_valid.
    task automatic xact(input logic [2:0] sel, input logic [31:0] v, input logic [31:0] base,
                        output logic [31:0] inst, output logic err, output int lat);
        @(negedge CLK);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        imm_sel   = sel;
        imm       = v;
        base_inst = base;
        #1;
        check("xact_in_ready", 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        inst = out_inst;
        err  = out_err;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] sel);
        case (sel)
            U_TYPE:  decode = {i[31:12], 12'd0};
            J_TYPE:  decode = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            I_TYPE:  decode = {{20{i[31]}}, i[31:20]};
            B_TYPE:  decode = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            S_TYPE:  decode = {{20{i[31]}}, i[31:25], i[11:7]};
            default: decode = {27'd0, i[24:20]};
        endcase
    endfunction

    logic [31:0] r_inst;
    logic        r_err;
    int          lat;

    logic [31:0] s_imm [8] = '{32'h00000000, 32'h00000004, 32'h0000001F, 32'h00000020,
                               32'h000007FF, 32'hFFFFF800, 32'hFFFFFFFF, 32'h00000800};
    logic [31:0] s_exp [8] = '{32'h00002023, 32'h00002223, 32'h00002FA3, 32'h02002023,
                               32'h7E002FA3, 32'h80002023, 32'hFE002FA3, 32'h80002023};
    bit          rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        imm_sel   = 3'd0;
        imm       = 32'd0;
        base_inst = 32'd0;
        RESETN    = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_enc_count", 32'(enc_count), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(negedge CLK);
        RESETN = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // I-type -2048 and latency
        xact(I_TYPE, 32'hFFFFF800, {25'd0, OP_IMM}, r_inst, r_err, lat);
        check("i_inst", r_inst, 32'h80000013);
        check("i_err", 32'(r_err), 32'd0);
        check("i_latency", 32'(lat), 32'd2);

        // B-type max and one past
        xact(B_TYPE, 32'h00000FFE, {25'd0, OP_BRANCH}, r_inst, r_err, lat);
        check("b_inst", r_inst, 32'h7E000FE3);
        check("b_err", 32'(r_err), 32'd0);
        xact(B_TYPE, 32'h00001000, {25'd0, OP_BRANCH}, r_inst, r_err, lat);
        check("b_ovf_inst", r_inst, 32'h80000063);
        check("b_ovf_err", 32'(r_err), 32'd1);
        check("b_err_count", 32'(err_count), 32'd1);
        check("b_enc_count", 32'(enc_count), 32'd3);

        // J-type -2 and U with low bits set
        xact(J_TYPE, 32'hFFFFFFFE, {25'd0, OP_JAL}, r_inst, r_err, lat);
        check("j_inst", r_inst, 32'hFFFFF06F);
        check("j_err", 32'(r_err), 32'd0);
        xact(U_TYPE, 32'h12345001, {25'd0, OP_LUI}, r_inst, r_err, lat);
        check("u_inst", r_inst, 32'h12345037);
        check("u_err", 32'(r_err), 32'd1);
        check("u_err_count", 32'(err_count), 32'd2);

        // SHAMT range, srai funct7 kept, illegal select
        xact(SHAMT, 32'd32, 32'h00001013, r_inst, r_err, lat);
        check("sh32_inst", r_inst, 32'h00001013);
        check("sh32_err", 32'(r_err), 32'd1);
        xact(SHAMT, 32'd5, 32'h40005013, r_inst, r_err, lat);
        check("sh5_inst", r_inst, 32'h40505013);
        check("sh5_err", 32'(r_err), 32'd0);
        xact(3'b111, 32'h00000000, 32'h12345678, r_inst, r_err, lat);
        check("ill_inst", r_inst, 32'h12345678);
        check("ill_err", 32'(r_err), 32'd1);
        check("ill_enc_count", 32'(enc_count), 32'd8);
        check("ill_err_count", 32'(err_count), 32'd4);

        // Backpressure stream of 8 S-type stores
        apply_reset();
        begin
            int tx = 0;
            int rx = 0;
            int cyc = 0;
            int occ = 0;
            while (rx < 8 && cyc < 200) begin
                out_ready = rdy_pat[cyc % 4];
                in_valid  = (tx < 8);
                imm_sel   = S_TYPE;
                imm       = s_imm[(tx < 8) ? tx : 0];
                base_inst = 32'h00002023;
                #1;
                check("bp_in_ready", 32'(in_ready), 32'(!(occ == 2 && !out_ready)));
                if (out_valid && out_ready) begin
                    check("bp_inst", out_inst, s_exp[rx]);
                    check("bp_err", 32'(out_err), 32'(rx == 7));
                    rx++;
                end
                if (in_valid && in_ready) tx++;
                occ = tx - rx;
                @(negedge CLK);
                cyc++;
            end
            in_valid = 1'b0;
            check("bp_received", 32'(rx), 32'd8);
            check("bp_enc_count", 32'(enc_count), 32'd8);
            check("bp_err_count", 32'(err_count), 32'd1);
        end

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_sel   = I_TYPE;
        imm       = 32'd1;
        base_inst = {25'd0, OP_IMM};
        repeat (2) @(negedge CLK);
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        #1;
        RESETN = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_inst", out_inst, 32'd0);
        check("mid_rst_enc_count", 32'(enc_count), 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        RESETN = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            check("post_rst_out_valid", 32'(out_valid), 32'd0);
        end

        // Round trip through the decode extender
        repeat (24) begin
            logic [31:0] r;
            logic [31:0] base;
            logic [31:0] v;
            logic [2:0]  sel;
            r    = $urandom;
            base = $urandom;
            sel  = 3'($urandom_range(0, 5));
            case (sel)
                U_TYPE:  v = r & 32'hFFFFF000;
                J_TYPE:  v = {{11{r[20]}}, r[20:1], 1'b0};
                B_TYPE:  v = {{19{r[12]}}, r[12:1], 1'b0};
                SHAMT:   v = {27'd0, r[4:0]};
                default: v = {{20{r[11]}}, r[11:0]};
            endcase
            xact(sel, v, base, r_inst, r_err, lat);
            check("rt_imm", decode(r_inst, sel), v);
            check("rt_err", 32'(r_err), 32'd0);
            check("rt_opcode", 32'(r_inst[6:0]), 32'(base[6:0]));
            if (sel == SHAMT) check("rt_funct7", 32'(r_inst[31:25]), 32'(base[31:25]));
        end

        // Counter saturation at full rate with illegal selects
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        imm_sel   = 3'b110;
        base_inst = 32'h00000013;
        repeat (65540) @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("sat_enc_count", 32'(enc_count), 32'h0000FFFF);
        check("sat_err_count", 32'(err_count), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
